// File: rtl/score_collector.sv
// score_collector: captures new per-slot results from the score bank and
// serialises them as unbiased {id, score} records through an RR arbiter and FIFO.
module score_collector #(
  parameter int SCORE_WIDTH = 12,
  parameter int ID_WIDTH    = 48,
  parameter int MODULES     = 4,
  parameter int ZERO        = 2048,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*MODULES*SCORE_WIDTH-1:0]  results,
  input  logic [2*MODULES*ID_WIDTH-1:0]     IDs,
  input  logic [2*MODULES-1:0]              vld,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ID_WIDTH-1:0]               out_id,
  output logic [SCORE_WIDTH-1:0]            out_score,
  output logic                              overflow,
  output logic [CNT_WIDTH-1:0]              n_out
);

  localparam int NSLOT = 2 * MODULES;
  localparam int PW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int RW    = ID_WIDTH + SCORE_WIDTH;

  logic [ID_WIDTH-1:0]    in_id   [NSLOT];
  logic [SCORE_WIDTH-1:0] in_raw  [NSLOT];

  // Slot 0 occupies the most significant field, as in the bank.
  for (genvar g = 0; g < NSLOT; g++) begin : g_unpack
    assign in_id[g]  = IDs[(NSLOT-1-g)*ID_WIDTH +: ID_WIDTH];
    assign in_raw[g] = results[(NSLOT-1-g)*SCORE_WIDTH +: SCORE_WIDTH];
  end

  logic [NSLOT-1:0]       vld_dly_q, vld_dly_d;
  logic [ID_WIDTH-1:0]    id_dly_q   [NSLOT];
  logic [ID_WIDTH-1:0]    id_dly_d   [NSLOT];
  logic [ID_WIDTH-1:0]    slot_id_q  [NSLOT];
  logic [ID_WIDTH-1:0]    slot_id_d  [NSLOT];
  logic [SCORE_WIDTH-1:0] slot_raw_q [NSLOT];
  logic [SCORE_WIDTH-1:0] slot_raw_d [NSLOT];
  logic [NSLOT-1:0]       pend_q, pend_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [AW:0]            wr_q, wr_d;
  logic [AW:0]            rd_q, rd_d;
  logic [RW-1:0]          mem_q [FIFO_DEPTH];

  logic [NSLOT-1:0] cap;
  logic [NSLOT-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    idx;
  logic             found;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;
  logic [RW-1:0]    wr_data;
  int               idx_i;

  always_comb begin
    cap        = '0;
    gnt        = '0;
    gnt_idx    = '0;
    idx        = '0;
    idx_i      = 0;
    found      = 1'b0;
    vld_dly_d  = vld;
    id_dly_d   = in_id;
    slot_id_d  = slot_id_q;
    slot_raw_d = slot_raw_q;

    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);

    for (int j = 0; j < NSLOT; j++) begin
      cap[j] = vld[j] &
               (~vld_dly_q[j] | (in_id[j] != id_dly_q[j]));
      if (cap[j]) begin
        slot_id_d[j]  = in_id[j];
        slot_raw_d[j] = in_raw[j];
      end
    end

    for (int k = 0; k < NSLOT; k++) begin
      idx_i = int'(rr_q) + k;
      if (idx_i >= NSLOT) idx_i = idx_i - NSLOT;
      idx = PW'(idx_i);
      if (!found && pend_q[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end

    // Full is the registered flag: a same-cycle read does not unblock a write.
    wr_en = found & ~full;
    if (wr_en) gnt[gnt_idx] = 1'b1;

    wr_data = {slot_id_q[gnt_idx],
               slot_raw_q[gnt_idx] - SCORE_WIDTH'(ZERO)};

    rr_d = rr_q;
    if (wr_en)
      rr_d = (gnt_idx == PW'(NSLOT-1)) ? '0 : gnt_idx + PW'(1);

    pend_d     = cap | (pend_q & ~gnt);
    overflow_d = overflow_q | (|(cap & pend_q & ~gnt));

    rd_en = ~empty & out_ready;
    wr_d  = wr_q + (AW+1)'(wr_en);
    rd_d  = rd_q + (AW+1)'(rd_en);
    cnt_d = cnt_q + CNT_WIDTH'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_dly_q  <= '0;
      pend_q     <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int j = 0; j < NSLOT; j++) begin
        id_dly_q[j]   <= '0;
        slot_id_q[j]  <= '0;
        slot_raw_q[j] <= '0;
      end
    end else begin
      vld_dly_q  <= vld_dly_d;
      id_dly_q   <= id_dly_d;
      slot_id_q  <= slot_id_d;
      slot_raw_q <= slot_raw_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_q[AW-1:0]] <= wr_data;
  end

  assign out_valid = ~empty;
  assign {out_id, out_score} = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign n_out     = cnt_q;

endmodule

// File: tb/tb_score_collector.sv
// tb_score_collector: directed stimulus with a queue scoreboard; a negedge
// monitor pops expected records on every output handshake.
module tb_score_collector;

  localparam int SW = 12;
  localparam int IW = 48;
  localparam int NS = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*SW-1:0] results;
  logic [NS*IW-1:0] IDs;
  logic [NS-1:0]  vld;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_id;
  logic [SW-1:0]  out_score;
  logic           overflow;
  logic [15:0]    n_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [IW+SW-1:0] exp_q[$];

  score_collector dut (
    .clk       (clk),
    .rst       (rst),
    .results   (results),
    .IDs       (IDs),
    .vld       (vld),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_score (out_score),
    .overflow  (overflow),
    .n_out     (n_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_record: got id=%0d score=%0d, none required",
                 out_id, $signed(out_score));
      end else begin
        logic [IW+SW-1:0] e;
        e = exp_q.pop_front();
        if ({out_id, out_score} !== e) begin
          n_bad++;
          $display("FAIL record: got id=%0d score=%0d, required id=%0d score=%0d",
                   out_id, $signed(out_score), e[IW+SW-1:SW], $signed(e[SW-1:0]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int sc);
    exp_q.push_back({IW'(id), SW'(sc)});
  endtask

  task automatic set_slot(input int j, input int id, input int raw);
    IDs[(NS-1-j)*IW +: IW]     = IW'(id);
    results[(NS-1-j)*SW +: SW] = SW'(raw);
    vld[j] = 1'b1;
  endtask

  task automatic do_reset();
    vld = '0;
    rst = 1'b0;
    tick(2);
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      tick(1);
      n++;
    end
    tick(3);
    check(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    results   = '0;
    IDs       = '0;
    vld       = '0;
    out_ready = 1'b1;
    do_reset();

    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_nout", 64'(n_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_id", 64'(out_id), 64'd0);
    check("rst_score", 64'(out_score), 64'd0);

    // single result with latency check
    set_slot(2, 7, 2083);
    push(7, 35);
    tick(1);
    check("lat_e0", 64'(out_valid), 64'd0);
    tick(1);
    check("lat_e1", 64'(out_valid), 64'd1);
    tick(9);
    vld = '0;
    drain("single_drain");
    check("single_nout", 64'(n_out), 64'd1);

    // all slots at once
    do_reset();
    for (int j = 0; j < NS; j++) begin
      set_slot(j, j, 2048 - j);
      push(j, -j);
    end
    tick(1);
    for (int k = 0; k < NS; k++) begin
      tick(1);
      check("burst_valid", 64'(out_valid), 64'd1);
    end
    vld = '0;
    drain("burst_drain");
    check("burst_nout", 64'(n_out), 64'd8);

    // round robin with same-cycle capture and grant on slot 0
    do_reset();
    set_slot(0, 100, 2049);
    set_slot(5, 105, 2053);
    push(100, 1);
    push(105, 5);
    push(200, 20);
    tick(1);
    set_slot(0, 200, 2068);
    tick(8);
    check("rr_ovf", 64'(overflow), 64'd0);
    vld = '0;
    drain("rr_drain");

    // backpressure: 20 results, FIFO holds 16, pend holds 4
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_slot(i % NS, 1000 + i, 2048 + i - 10);
      push(1000 + i, i - 10);
      tick(1);
    end
    tick(4);
    check("bp_ovf", 64'(overflow), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_head", 64'(out_id), 64'd1000);
    check("bp_nout", 64'(n_out), 64'd0);
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_nout_end", 64'(n_out), 64'd20);

    // overflow on slot 3 while FIFO is full
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_slot(i % NS, 2000 + i, 2048 + i);
      push(2000 + i, i);
      tick(1);
    end
    tick(3);
    set_slot(3, 10, 2058);
    tick(1);
    check("ovf_first", 64'(overflow), 64'd0);
    set_slot(3, 11, 2059);
    push(11, 11);
    tick(1);
    check("ovf_set", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_sticky", 64'(overflow), 64'd1);

    // reset with 5 queued records
    out_ready = 1'b0;
    vld = '0;
    tick(1);
    for (int i = 0; i < 5; i++) set_slot(i, 3000 + i, 2048 - 100 + i);
    tick(8);
    check("mid_valid_pre", 64'(out_valid), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    tick(1);
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_nout", 64'(n_out), 64'd0);
    check("mid_ovf", 64'(overflow), 64'd0);
    check("mid_id", 64'(out_id), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) push(3000 + i, i - 100);
    out_ready = 1'b1;
    drain("mid_drain");
    check("mid_nout_end", 64'(n_out), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
